pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
// Parametrised inter-stage pipeline register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Replaces the plain enable-gated register with a valid/ready handshake backed by a 2-entry skid buffer.
// Stages stall via backpressure without a global enable, and a synchronous flush kills in-flight instructions.
// Empty slots present a configurable bubble word: all-zero is sll $0,$0,0, i.e. a NOP.
// PARAMETERS
// DATA_W      197  payload width: Instr,PC,PC4,PC8,ALUout,MemData 32b each + RegAddr 5b
// BUBBLE_ZERO 1    1: out_data forced to BUBBLE_VAL while out_valid=0; 0: out_data holds last value
// BUBBLE_VAL  0    DATA_W-bit word presented as a bubble and loaded on reset/flush
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       asynchronous, active-high; clears all state
// flush      in   1       synchronous kill of every stored entry
// in_valid   in   1       upstream stage offers in_data
// in_ready   out  1       this block accepts in_data this cycle
// in_data    in   DATA_W  upstream payload
// out_valid  out  1       out_data holds a live instruction
// out_ready  in   1       downstream stage consumes out_data this cycle
// out_data   out  DATA_W  payload to downstream stage
// occupancy  out  2       entries held: 0, 1 or 2
// BEHAVIOUR
// - Storage: main reg M drives out_data; skid reg S. FSM: EMPTY(occ0), ONE(M live), FULL(M+S live).
// - Accept when in_valid&in_ready; consume when out_valid&out_ready.
// - in_ready = (state!=FULL), taken from a flop with no combinational path from out_ready.
// - out_valid = (state!=EMPTY), taken from a flop.
// - Latency: data accepted at edge N appears on out_data after edge N when the block was EMPTY.
// - Transitions (no flush):
//   EMPTY + accept -> ONE, M<=in_data.
//   ONE + accept & consume -> ONE, M<=in_data.
//   ONE + accept & !consume -> FULL, S<=in_data.
//   ONE + consume & !accept -> EMPTY.
//   FULL + consume -> ONE, M<=S.
//   FULL never accepts, because in_ready=0.
//   Any other combination holds state.
// - Order is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
// - flush=1 at an edge: state->EMPTY, M<=BUBBLE_VAL, S<=BUBBLE_VAL.
//   A same-cycle accept is discarded and a same-cycle consume still counts downstream.
//   After that edge in_ready=1.
// - reset (async, any time, mid-transfer included): state=EMPTY, M=S=BUBBLE_VAL, out_valid=0,
//   in_ready=1, occupancy=0. Normal operation resumes at the first edge after reset deasserts.
// - reset has priority over flush, and flush has priority over handshake.
// - BUBBLE_ZERO=1: out_data=BUBBLE_VAL whenever out_valid=0.
//   In that mode WB sees a NOP, and RegAddr=0 writes $0, which is harmless.
// - out_data is not changed while out_valid&!out_ready (stable under stall).
// - occupancy mirrors state: EMPTY=0, ONE=1, FULL=2. No overflow or underflow is possible.
// TESTING
// 1 reset mid-stream with occ=2 -> same cycle out_valid=0, out_data=0, in_ready=1, occ=0.
// 2 Streaming, out_ready=1, in_valid=1 with payloads A,B,C on edges 1-3
//   -> out_data=A,B,C after edges 1-3; occ stays 1; in_ready stays 1.
// 3 Backpressure: out_ready=0, push A then B -> occ=2, in_ready=0, out_data=A held;
//   C offered is not taken. Then out_ready=1 -> A, B, C emerge in order.
// 4 flush at occ=2 together with in_valid=1 (D) -> next cycle occ=0, out_valid=0, out_data=0;
//   D never appears.
// 5 FULL state with out_ready=1 and in_valid=1 at the same edge
//   -> M<=S, occ=1, new data not accepted that edge, accepted on the next.
// 6 BUBBLE_ZERO=0, drain to EMPTY -> out_data keeps the last payload while out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Inter-stage pipeline register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM,
// MEM/WB). It carries a valid/ready handshake and a 2-entry skid buffer, so a
// stage can stall through backpressure without a global enable. A synchronous
// flush kills every stored entry. An empty slot presents a configurable bubble
// word. All-zero is sll $0,$0,0, which is a NOP.
//
// Storage:
//   M (main) drives out_data. S (skid) catches one extra word when the
//   downstream stage stalls in the same cycle that upstream delivers.
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high; clears all state
//   flush      in   1       synchronous kill of every stored entry
//   in_valid   in   1       upstream offers in_data
//   in_ready   out  1       this block accepts in_data this cycle (registered)
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a live instruction (registered)
//   out_ready  in   1       downstream consumes out_data this cycle
//   out_data   out  DATA_W  payload to downstream stage
//   occupancy  out  2       entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int                 DATA_W      = 197,
  parameter bit                 BUBBLE_ZERO = 1'b1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occupancy_q, occupancy_d;

  logic accept;
  logic consume;

  // Handshakes use only the registered ready/valid. in_ready therefore has
  // no combinational path from out_ready.
  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    if (flush) begin
      // A same-cycle accept is dropped. A same-cycle consume was already
      // seen by downstream, so clearing the storage is enough.
      state_d = ST_EMPTY;
      m_d     = BUBBLE_VAL;
      s_d     = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            m_d     = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            m_d = in_data;
          end else if (accept) begin
            // Downstream stalled, so park the new word in the skid reg.
            state_d = ST_FULL;
            s_d     = in_data;
          end else if (consume) begin
            // M keeps its payload, so out_data can hold it when BUBBLE_ZERO=0.
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so accept cannot occur.
          if (consume) begin
            state_d = ST_ONE;
            m_d     = s_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // The status outputs are registered copies derived from the next state.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    unique case (state_d)
      ST_EMPTY: occupancy_d = 2'd0;
      ST_ONE:   occupancy_d = 2'd1;
      ST_FULL:  occupancy_d = 2'd2;
      default:  occupancy_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      m_q         <= BUBBLE_VAL;
      s_q         <= BUBBLE_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;

  generate
    if (BUBBLE_ZERO) begin : g_bubble
      assign out_data = out_valid_q ? m_q : BUBBLE_VAL;
    end else begin : g_hold
      assign out_data = m_q;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Two instances share all inputs. One instance has BUBBLE_ZERO=1 and the other
// has BUBBLE_ZERO=0. The reference model is a FIFO queue of at most two words,
// plus the last word that left the queue. On every falling edge the bench
// compares both instances against that model. Directed sequences pin the
// model to hand-computed literal values. A randomized phase follows, with
// flush and asynchronous reset mixed into the stimulus.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;
  localparam int W = 197;
  localparam logic [W-1:0] BV = '0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready1, out_valid1, in_ready0, out_valid0;
  logic [W-1:0] out_data1, out_data0;
  logic [1:0]   occ1, occ0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(W), .BUBBLE_ZERO(1'b1), .BUBBLE_VAL(BV)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(W), .BUBBLE_ZERO(1'b0), .BUBBLE_VAL(BV)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: the FIFO contents, plus the last word that left it.
  logic [W-1:0] q[$];
  logic [W-1:0] last_out = BV;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last_out = BV;
    end else begin
      automatic bit acc = in_valid && (q.size() < 2);
      automatic bit con = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
        last_out = BV;
      end else begin
        if (con) last_out = q.pop_front();
        if (acc) q.push_back(in_data);
      end
    end
  end

  // Compare process: runs on every falling edge, away from the active edge.
  always @(negedge clk) begin
    automatic int n = q.size();
    automatic logic [W-1:0] head = (n > 0) ? q[0] : BV;
    chk("out_valid1", W'(out_valid1), W'(n > 0));
    chk("in_ready1",  W'(in_ready1),  W'(n < 2));
    chk("occ1",       W'(occ1),       W'(n));
    chk("out_data1",  out_data1,      (n > 0) ? head : BV);
    chk("out_valid0", W'(out_valid0), W'(n > 0));
    chk("in_ready0",  W'(in_ready0),  W'(n < 2));
    chk("occ0",       W'(occ0),       W'(n));
    chk("out_data0",  out_data0,      (n > 0) ? head : last_out);
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w;
  endfunction

  // Wait for the next edge, then move off it before driving new inputs.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam logic [W-1:0] A = W'(197'h1A1A_0000_1111);
  localparam logic [W-1:0] B = W'(197'h2B2B_0000_2222);
  localparam logic [W-1:0] C = W'(197'h3C3C_0000_3333);
  localparam logic [W-1:0] D = W'(197'h4D4D_0000_4444);

  initial begin
    // Reset state.
    #12;
    chk("rst_valid", W'(out_valid1), '0);
    chk("rst_ready", W'(in_ready1), W'(1));
    reset = 1'b0;
    step();

    // Streaming: A, B, C on consecutive edges.
    out_ready = 1'b1; in_valid = 1'b1; in_data = A;
    step(); chk("stream_A", out_data1, A); chk("stream_occ", W'(occ1), W'(1));
    in_data = B;
    step(); chk("stream_B", out_data1, B); chk("stream_rdy", W'(in_ready1), W'(1));
    in_data = C;
    step(); chk("stream_C", out_data1, C);
    in_valid = 1'b0;
    step(); chk("drain_hold0", out_data0, C); chk("drain_bub1", out_data1, BV);

    // Backpressure: push A then B; C is refused while FULL.
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    step(); in_data = B;
    step(); chk("bp_occ", W'(occ1), W'(2)); chk("bp_rdy", W'(in_ready1), '0);
    chk("bp_head", out_data1, A);
    in_data = C;
    step(); chk("bp_hold", out_data1, A); chk("bp_occ2", W'(occ1), W'(2));
    // FULL with consume and offer on the same edge: M<=S, C not yet taken.
    out_ready = 1'b1;
    step(); chk("full_B", out_data1, B); chk("full_occ", W'(occ1), W'(1));
    step(); chk("full_C", out_data1, C);
    in_valid = 1'b0;
    step(); chk("bp_empty", W'(occ1), '0);

    // Flush at occupancy 2 with D offered on the same edge.
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    step(); in_data = B;
    step(); flush = 1'b1; in_data = D;
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_occ", W'(occ1), '0); chk("fl_valid", W'(out_valid1), '0);
    chk("fl_data", out_data1, BV); chk("fl_rdy", W'(in_ready1), W'(1));
    step(); step(); chk("fl_noD", W'(out_valid1), '0);

    // Async reset mid-stream while FULL.
    out_ready = 1'b0; in_valid = 1'b1; in_data = C;
    step(); in_data = D;
    step(); chk("pre_rst_occ", W'(occ1), W'(2));
    reset = 1'b1; #1;
    chk("mr_valid", W'(out_valid1), '0); chk("mr_data", out_data1, BV);
    chk("mr_rdy", W'(in_ready1), W'(1)); chk("mr_occ", W'(occ1), '0);
    chk("mr_data0", out_data0, BV);
    step(); reset = 1'b0; in_valid = 1'b0;
    step();

    // Randomized traffic with occasional flush and asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = rand_word();
      flush     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
